// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-side definitions: data width, the canonical NOP and fetch FSM states.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR_C = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: hazard/redirect inputs, instruction-memory handshake and the IF/ID outputs.
interface instruction_fetch_unit_if;
  import rv32_pkg::*;

  logic            STALL;
  logic            BRANCH_TAKEN;
  logic [XLEN-1:0] BRANCH_TARGET;
  logic [XLEN-1:0] IMEM_READDATA;
  logic            IMEM_BUSYWAIT;
  logic            IMEM_READ;
  logic [XLEN-1:0] IMEM_ADDR;
  logic [XLEN-1:0] INSTRUCTION;
  logic [XLEN-1:0] PC_OUT;
  logic [XLEN-1:0] PC_PLUS4;
  logic            INSTR_VALID;
  logic            BUSY_WAIT;
  logic            FETCH_FAULT;

  modport master (
    input  STALL, BRANCH_TAKEN, BRANCH_TARGET, IMEM_READDATA, IMEM_BUSYWAIT,
    output IMEM_READ, IMEM_ADDR, INSTRUCTION, PC_OUT, PC_PLUS4, INSTR_VALID,
           BUSY_WAIT, FETCH_FAULT
  );

  modport slave (
    output STALL, BRANCH_TAKEN, BRANCH_TARGET, IMEM_READDATA, IMEM_BUSYWAIT,
    input  IMEM_READ, IMEM_ADDR, INSTRUCTION, PC_OUT, PC_PLUS4, INSTR_VALID,
           BUSY_WAIT, FETCH_FAULT
  );

endinterface

// File: rtl/instruction_fetch_unit_skid.sv
// One-entry {instr, pc} holding slot for a fetch that completes while decode is stalled.
module fetch_skid_buffer
  import rv32_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            full_o
);

  logic            full_q, full_d;
  logic [XLEN-1:0] instr_q, pc_q;
  logic            store;

  // An empty buffer popped in the same cycle it is pushed hands the entry straight through.
  assign store   = push_i && !(pop_i && !full_q) && !flush_i;
  assign instr_o = full_q ? instr_q : instr_i;
  assign pc_o    = full_q ? pc_q    : pc_i;
  assign full_o  = full_q;

  always_comb begin
    full_d = full_q;
    if (flush_i)     full_d = 1'b0;
    else if (store)  full_d = 1'b1;
    else if (pop_i)  full_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) full_q <= 1'b0;
    else         full_q <= full_d;
  end

  always_ff @(posedge clk_i) begin
    if (store) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, runs the busy-wait fetch handshake, applies redirects and drives IF/ID.
module instruction_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR    = NOP_INSTR_C
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  instruction_fetch_unit_if.master  bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            vld_q, vld_d;

  logic            imem_read, complete, fetch_done;
  logic [XLEN-1:0] imem_addr;
  logic            skid_push, skid_pop, skid_flush, skid_full;
  logic [XLEN-1:0] skid_instr, skid_pc;

  assign imem_read  = ((state_q == FETCH) && !skid_full) || (state_q == DRAIN);
  assign imem_addr  = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign complete   = imem_read && !bus.IMEM_BUSYWAIT;
  assign fetch_done = (state_q == FETCH) && complete;

  fetch_skid_buffer u_skid (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .flush_i (skid_flush),
    .instr_i (bus.IMEM_READDATA),
    .pc_i    (pc_q),
    .instr_o (skid_instr),
    .pc_o    (skid_pc),
    .full_o  (skid_full)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    fault_d      = fault_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    pc4_d        = pc4_q;
    vld_d        = vld_q;
    skid_push    = 1'b0;
    skid_pop     = 1'b0;
    skid_flush   = 1'b0;

    if (bus.BRANCH_TAKEN) begin
      skid_flush = 1'b1;
      instr_d    = NOP_INSTR;
      vld_d      = 1'b0;
      if (|bus.BRANCH_TARGET[1:0]) begin
        fault_d = 1'b1;
        state_d = FAULT;
      end else begin
        fault_d = 1'b0;
        pc_d    = bus.BRANCH_TARGET;
        // A request the memory is still working on must finish at its original address.
        if (imem_read && bus.IMEM_BUSYWAIT) begin
          state_d      = DRAIN;
          drain_addr_d = imem_addr;
        end else begin
          state_d = FETCH;
        end
      end
    end else begin
      case (state_q)
        IDLE:    state_d = FETCH;
        DRAIN:   if (complete) state_d = FETCH;
        default: state_d = state_q;
      endcase

      if (fetch_done) pc_d = pc_q + 32'd4;

      if (bus.STALL) begin
        skid_push = fetch_done;
      end else if (skid_full) begin
        skid_pop = 1'b1;
        instr_d  = skid_instr;
        pc_out_d = skid_pc;
        pc4_d    = skid_pc + 32'd4;
        vld_d    = 1'b1;
      end else if (fetch_done) begin
        instr_d  = bus.IMEM_READDATA;
        pc_out_d = pc_q;
        pc4_d    = pc_q + 32'd4;
        vld_d    = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        vld_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      pc_q         <= RESET_VECTOR;
      drain_addr_q <= RESET_VECTOR;
      fault_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc_out_q     <= '0;
      pc4_q        <= '0;
      vld_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      fault_q      <= fault_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      pc4_q        <= pc4_d;
      vld_q        <= vld_d;
    end
  end

  assign bus.IMEM_READ   = imem_read;
  assign bus.IMEM_ADDR   = imem_addr;
  assign bus.INSTRUCTION = instr_q;
  assign bus.PC_OUT      = pc_out_q;
  assign bus.PC_PLUS4    = pc4_q;
  assign bus.INSTR_VALID = vld_q;
  assign bus.BUSY_WAIT   = !vld_q;
  assign bus.FETCH_FAULT = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational instruction memory model.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(
    .RESET_VECTOR (32'h0000_0000),
    .NOP_INSTR    (32'h0000_0013)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0050_0093;
      32'h0000_0004: mem_word = 32'h0010_0113;
      default:       mem_word = {16'hC0DE, a[15:0]};
    endcase
  endfunction

  assign bus.IMEM_READDATA = mem_word(bus.IMEM_ADDR);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_if(input string tag, input logic vld, input logic [31:0] ins,
                          input logic [31:0] pc);
    check({tag, ".valid"}, {31'd0, bus.INSTR_VALID}, {31'd0, vld});
    check({tag, ".instr"}, bus.INSTRUCTION, ins);
    if (vld) begin
      check({tag, ".pc"},   bus.PC_OUT, pc);
      check({tag, ".pc4"},  bus.PC_PLUS4, pc + 32'd4);
      check({tag, ".busy"}, {31'd0, bus.BUSY_WAIT}, 32'd0);
    end else begin
      check({tag, ".busy"}, {31'd0, bus.BUSY_WAIT}, 32'd1);
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.STALL         = 1'b0;
    bus.BRANCH_TAKEN  = 1'b0;
    bus.BRANCH_TARGET = 32'h0;
    bus.IMEM_BUSYWAIT = 1'b0;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.instr", bus.INSTRUCTION, 32'h0000_0013);
    check("rst.valid", {31'd0, bus.INSTR_VALID}, 32'd0);
    check("rst.read",  {31'd0, bus.IMEM_READ}, 32'd0);
    check("rst.addr",  bus.IMEM_ADDR, 32'h0);
    check("rst.busy",  {31'd0, bus.BUSY_WAIT}, 32'd1);
    check("rst.fault", {31'd0, bus.FETCH_FAULT}, 32'd0);
    check("rst.pc",    bus.PC_OUT, 32'h0);
    check("rst.pc4",   bus.PC_PLUS4, 32'h0);
    rst_n = 1'b1;
    #1;
    check("idle.read", {31'd0, bus.IMEM_READ}, 32'd0);
    tick();
    check("fetch0.read", {31'd0, bus.IMEM_READ}, 32'd1);
    check("fetch0.addr", bus.IMEM_ADDR, 32'h0);

    // Zero-wait stream
    tick();
    check_if("s0", 1'b1, 32'h0050_0093, 32'h0);
    check("s0.addr", bus.IMEM_ADDR, 32'h4);
    tick();
    check_if("s1", 1'b1, 32'h0010_0113, 32'h4);
    check("s1.addr", bus.IMEM_ADDR, 32'h8);

    // Three wait states at 0x8
    bus.IMEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_if("wait", 1'b0, 32'h0000_0013, 32'h0);
      check("wait.addr", bus.IMEM_ADDR, 32'h8);
      check("wait.read", {31'd0, bus.IMEM_READ}, 32'd1);
    end
    bus.IMEM_BUSYWAIT = 1'b0;
    tick();
    check_if("w8", 1'b1, 32'hC0DE_0008, 32'h8);
    check("w8.addr", bus.IMEM_ADDR, 32'hC);

    // Redirect to 0x100 while 0xC is busy
    bus.IMEM_BUSYWAIT = 1'b1;
    bus.BRANCH_TAKEN  = 1'b1;
    bus.BRANCH_TARGET = 32'h100;
    tick();
    bus.BRANCH_TAKEN  = 1'b0;
    check_if("drain0", 1'b0, 32'h0000_0013, 32'h0);
    check("drain0.addr", bus.IMEM_ADDR, 32'hC);
    tick();
    check("drain1.addr", bus.IMEM_ADDR, 32'hC);
    check("drain1.valid", {31'd0, bus.INSTR_VALID}, 32'd0);
    bus.IMEM_BUSYWAIT = 1'b0;
    tick();
    check_if("drained", 1'b0, 32'h0000_0013, 32'h0);
    check("drained.addr", bus.IMEM_ADDR, 32'h100);
    tick();
    check_if("t100", 1'b1, 32'hC0DE_0100, 32'h100);

    // Zero-wait redirect back to 0x8, then stall while 0x10 completes
    bus.BRANCH_TAKEN  = 1'b1;
    bus.BRANCH_TARGET = 32'h8;
    tick();
    bus.BRANCH_TAKEN  = 1'b0;
    check_if("rd8", 1'b0, 32'h0000_0013, 32'h0);
    check("rd8.addr", bus.IMEM_ADDR, 32'h8);
    tick();
    check_if("r8", 1'b1, 32'hC0DE_0008, 32'h8);
    tick();
    check_if("rC", 1'b1, 32'hC0DE_000C, 32'hC);
    check("rC.addr", bus.IMEM_ADDR, 32'h10);
    bus.STALL = 1'b1;
    tick();
    check_if("st0", 1'b1, 32'hC0DE_000C, 32'hC);
    check("st0.read", {31'd0, bus.IMEM_READ}, 32'd0);
    tick();
    check_if("st1", 1'b1, 32'hC0DE_000C, 32'hC);
    check("st1.read", {31'd0, bus.IMEM_READ}, 32'd0);
    bus.STALL = 1'b0;
    tick();
    check_if("sk10", 1'b1, 32'hC0DE_0010, 32'h10);
    check("sk10.addr", bus.IMEM_ADDR, 32'h14);
    check("sk10.read", {31'd0, bus.IMEM_READ}, 32'd1);
    tick();
    check_if("r14", 1'b1, 32'hC0DE_0014, 32'h14);
    tick();
    check_if("r18", 1'b1, 32'hC0DE_0018, 32'h18);

    // Misaligned redirect, then recovery
    bus.BRANCH_TAKEN  = 1'b1;
    bus.BRANCH_TARGET = 32'h102;
    tick();
    bus.BRANCH_TAKEN  = 1'b0;
    check("mis.fault", {31'd0, bus.FETCH_FAULT}, 32'd1);
    check("mis.read",  {31'd0, bus.IMEM_READ}, 32'd0);
    check_if("mis", 1'b0, 32'h0000_0013, 32'h0);
    tick();
    check("mis2.fault", {31'd0, bus.FETCH_FAULT}, 32'd1);
    check("mis2.read",  {31'd0, bus.IMEM_READ}, 32'd0);
    bus.BRANCH_TAKEN  = 1'b1;
    bus.BRANCH_TARGET = 32'h200;
    tick();
    bus.BRANCH_TAKEN  = 1'b0;
    check("rec.fault", {31'd0, bus.FETCH_FAULT}, 32'd0);
    check("rec.addr",  bus.IMEM_ADDR, 32'h200);
    check("rec.read",  {31'd0, bus.IMEM_READ}, 32'd1);
    tick();
    check_if("r200", 1'b1, 32'hC0DE_0200, 32'h200);

    // Redirect beats stall; PC wraps past the top of memory
    bus.STALL         = 1'b1;
    bus.BRANCH_TAKEN  = 1'b1;
    bus.BRANCH_TARGET = 32'hFFFF_FFFC;
    tick();
    bus.BRANCH_TAKEN  = 1'b0;
    bus.STALL         = 1'b0;
    check_if("rdst", 1'b0, 32'h0000_0013, 32'h0);
    check("rdst.addr", bus.IMEM_ADDR, 32'hFFFF_FFFC);
    tick();
    check("wrap.valid", {31'd0, bus.INSTR_VALID}, 32'd1);
    check("wrap.pc",    bus.PC_OUT, 32'hFFFF_FFFC);
    check("wrap.pc4",   bus.PC_PLUS4, 32'h0);
    check("wrap.addr",  bus.IMEM_ADDR, 32'h0);

    // Reset during a waiting access
    bus.IMEM_BUSYWAIT = 1'b1;
    tick();
    check("busy.addr", bus.IMEM_ADDR, 32'h0);
    rst_n = 1'b0;
    #1;
    check("mrst.valid", {31'd0, bus.INSTR_VALID}, 32'd0);
    check("mrst.read",  {31'd0, bus.IMEM_READ}, 32'd0);
    check("mrst.pc",    bus.PC_OUT, 32'h0);
    @(negedge clk);
    bus.IMEM_BUSYWAIT = 1'b0;
    rst_n = 1'b1;
    tick();
    check("mrel.valid", {31'd0, bus.INSTR_VALID}, 32'd0);
    check("mrel.read",  {31'd0, bus.IMEM_READ}, 32'd1);
    check("mrel.addr",  bus.IMEM_ADDR, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
